// File: rtl/aes_pkg.sv
// Shared AES decrypt constants: state width, inverse S-box, GF(2^8) helpers
// and the InvShiftRows byte-index map.
package aes_pkg;

    localparam int DATA_W_DEF = 128;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Output byte k (k = 4*col + row, byte 0 in the MSBs) comes from input byte ISR_MAP[k].
    localparam int ISR_MAP [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // One state column, row 0 in the MSBs.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    assign result = INV_SBOX[value];

endmodule

// File: rtl/inv_round.sv
// Pipelined AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns,
// one register stage each. Define INV_ROUND_LAST_EN to add the last_round bypass port.
module inv_round
    import aes_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF  // only 128 is meaningful
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              data_valid_in,
    input  logic              key_valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] round_key,
`ifdef INV_ROUND_LAST_EN
    input  logic              last_round,
`endif
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              key_err
);

    logic              accept;
    logic              last_in;
    logic [DATA_W-1:0] isr;
    logic [DATA_W-1:0] isb;
    logic [DATA_W-1:0] imc;

    logic              s1_valid, s2_valid, s3_valid;
    logic [DATA_W-1:0] s1_data, s2_data, s3_data;
    logic [DATA_W-1:0] s1_key, s2_key;
    logic              s1_last, s2_last, s3_last;

    assign accept = data_valid_in & key_valid_in;

`ifdef INV_ROUND_LAST_EN
    assign last_in = last_round;
`else
    assign last_in = 1'b0;
`endif

    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign isr[DATA_W-1-8*k -: 8] = data_in[DATA_W-1-8*ISR_MAP[k] -: 8];

        inv_sbox u_inv_sbox (
            .value  (s1_data[DATA_W-1-8*k -: 8]),
            .result (isb[DATA_W-1-8*k -: 8])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign imc[DATA_W-1-32*c -: 32] = inv_mix_col(s3_data[DATA_W-1-32*c -: 32]);
    end

    // Key and last_round travel with their state so a key change never hits in-flight data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            valid_out <= 1'b0;
            key_err   <= 1'b0;
            s1_data   <= '0;
            s2_data   <= '0;
            s3_data   <= '0;
            s1_key    <= '0;
            s2_key    <= '0;
            s1_last   <= 1'b0;
            s2_last   <= 1'b0;
            s3_last   <= 1'b0;
            data_out  <= '0;
        end else begin
            s1_valid  <= accept;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            valid_out <= s3_valid;
            key_err   <= data_valid_in & ~key_valid_in;
            if (accept) begin
                s1_data <= isr;
                s1_key  <= round_key;
                s1_last <= last_in;
            end
            if (s1_valid) begin
                s2_data <= isb;
                s2_key  <= s1_key;
                s2_last <= s1_last;
            end
            if (s2_valid) begin
                s3_data <= s2_data ^ s2_key;
                s3_last <= s2_last;
            end
            if (s3_valid) begin
                data_out <= s3_last ? s3_data : imc;
            end
        end
    end

endmodule

// File: tb/tb_inv_round.sv
// Bench for inv_round: directed vector table, hand sequences for key_err/reset/back-to-back,
// and random traffic scored against a matrix-level inverse-round model.
module tb_inv_round;

    logic         clk = 1'b0;
    logic         reset;
    logic         data_valid_in;
    logic         key_valid_in;
    logic [127:0] data_in;
    logic [127:0] round_key;
    logic         last_in;
    logic         valid_out;
    logic [127:0] data_out;
    logic         key_err;

    int n_tests = 0;
    int n_fail  = 0;

    inv_round #(.DATA_W(128)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_valid_in (data_valid_in),
        .key_valid_in  (key_valid_in),
        .data_in       (data_in),
        .round_key     (round_key),
`ifdef INV_ROUND_LAST_EN
        .last_round    (last_in),
`endif
        .valid_out     (valid_out),
        .data_out      (data_out),
        .key_err       (key_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] inv_sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Inverse S-box from its definition: undo the affine map, then take the field inverse.
    task automatic build_inv_sbox();
        logic [7:0] y;
        logic [7:0] x;
        for (int v = 0; v < 256; v++) begin
            y = v[7:0];
            x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
            inv_sb[v] = 8'h00;
            if (x != 8'h00) begin
                for (int z = 1; z < 256; z++) begin
                    if (gmul(x, z[7:0]) == 8'h01) inv_sb[v] = z[7:0];
                end
            end
        end
    endtask

    function automatic logic [127:0] model_round(input logic [127:0] d, input logic [127:0] k,
                                                 input logic last);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] u [4][4];
        logic [7:0] coef [4];
        logic [127:0] r;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                s[w][c] = d[127-8*(4*c+w) -: 8];
        for (int w = 0; w < 4; w++)
            for (int c = 0; c < 4; c++)
                t[w][(c+w)%4] = s[w][c];
        for (int w = 0; w < 4; w++)
            for (int c = 0; c < 4; c++)
                t[w][c] = inv_sb[t[w][c]] ^ k[127-8*(4*c+w) -: 8];
        for (int w = 0; w < 4; w++)
            for (int c = 0; c < 4; c++) begin
                if (last) u[w][c] = t[w][c];
                else begin
                    u[w][c] = 8'h00;
                    for (int j = 0; j < 4; j++)
                        u[w][c] = u[w][c] ^ gmul(coef[(j-w+4)%4], t[j][c]);
                end
            end
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = u[w][c];
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard: expected results with the cycle number on which valid_out must show them.
    logic [127:0] exp_q [$];
    int           due_q [$];
    int           cyc = 0;
    logic         exp_kerr = 1'b0;
    logic [127:0] last_exp = '0;
    int           vcount = 0;
    int           run = 0;
    int           max_run = 0;

    always @(posedge clk) begin
        cyc++;
        exp_kerr = !reset && data_valid_in && !key_valid_in;
        if (!reset && data_valid_in && key_valid_in) begin
            exp_q.push_back(model_round(data_in, round_key, last_in));
            due_q.push_back(cyc + 3);
        end
    end

    always @(negedge clk) begin
        logic exp_v;
        if (reset) begin
            check("rst_valid_out", {127'b0, valid_out}, '0);
            check("rst_data_out", data_out, '0);
            check("rst_key_err", {127'b0, key_err}, '0);
            run = 0;
        end else begin
            exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
            check("valid_out", {127'b0, valid_out}, {127'b0, exp_v});
            if (exp_v) begin
                last_exp = exp_q.pop_front();
                void'(due_q.pop_front());
            end
            check("data_out", data_out, last_exp);
            check("key_err", {127'b0, key_err}, {127'b0, exp_kerr});
            if (valid_out) begin
                vcount++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic dv, input logic kv, input logic [127:0] d,
                         input logic [127:0] k, input logic l);
        @(negedge clk);
        #1;
        data_valid_in = dv;
        key_valid_in  = kv;
        data_in       = d;
        round_key     = k;
        last_in       = l;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];
    int   n_vec;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc0;
        logic l;
        reset = 1'b1;
        data_valid_in = 1'b0;
        key_valid_in  = 1'b0;
        data_in   = '0;
        round_key = '0;
        last_in   = 1'b0;
        build_inv_sbox();

        n_vec = 0;
        vecs[n_vec] = '{128'h0, 128'h0, 1'b0, {16{8'h52}}}; n_vec++;
        vecs[n_vec] = '{128'h0, {16{8'hff}}, 1'b0, {16{8'had}}}; n_vec++;
        vecs[n_vec] = '{128'h0, {8'h01, 120'h0}, 1'b0, {32'h5c5b5f59, {12{8'h52}}}}; n_vec++;
        vecs[n_vec] = '{128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h549932d1f08557681093ed9cbe2c974e,
                        1'b0, 128'h54d990a16ba09ab596bbf40ea111702f}; n_vec++;
`ifdef INV_ROUND_LAST_EN
        vecs[n_vec] = '{128'h0, {8'h01, 120'h0}, 1'b1, {32'h53525252, {12{8'h52}}}}; n_vec++;
`endif

        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Directed table: result must show on the fourth edge counting the accepting one.
        for (int i = 0; i < n_vec; i++) begin
            drive(1'b1, 1'b1, vecs[i].data, vecs[i].key, vecs[i].last);
            idle();
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_valid", i), {127'b0, valid_out}, 128'd1);
            check($sformatf("vec%0d_data", i), data_out, vecs[i].exp);
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), {127'b0, valid_out}, 128'd0);
        end

        // Eight back-to-back states, new key every cycle.
        vc0 = vcount;
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef INV_ROUND_LAST_EN
            l = 1'($urandom_range(0, 1));
`else
            l = 1'b0;
`endif
            drive(1'b1, 1'b1, rand128(), {rand128() & ~128'hff, 8'(i)}, l);
        end
        idle();
        repeat (6) @(negedge clk);
        check("b2b_count", 128'(vcount - vc0), 128'd8);
        check("b2b_run", 128'(max_run), 128'd8);

        // Missing key: one-cycle key_err and nothing emerges.
        vc0 = vcount;
        drive(1'b1, 1'b0, rand128(), rand128(), 1'b0);
        @(negedge clk);
        check("kerr_pulse", {127'b0, key_err}, 128'd1);
        #1 data_valid_in = 1'b0;
        key_valid_in = 1'b1;
        @(negedge clk);
        check("kerr_clear", {127'b0, key_err}, 128'd0);
        repeat (5) @(negedge clk);
        check("kerr_no_valid", 128'(vcount - vc0), 128'd0);

        // Reset with states in flight, then accept on the first edge after release.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, rand128(), rand128(), 1'b0);
        idle();
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        due_q.delete();
        last_exp = '0;
        exp_kerr = 1'b0;
        vc0 = vcount;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_no_valid", 128'(vcount - vc0), 128'd0);
        check("rst_data_zero", data_out, '0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        data_valid_in = 1'b1;
        key_valid_in  = 1'b1;
        data_in   = '0;
        round_key = '0;
        last_in   = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        check("post_rst_data", data_out, {16{8'h52}});

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
`ifdef INV_ROUND_LAST_EN
            l = 1'($urandom_range(0, 1));
`else
            l = 1'b0;
`endif
            drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) != 0), rand128(), rand128(), l);
        end
        idle();
        repeat (6) @(negedge clk);
        check("drain_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_round.md
INV_ROUND -- requirements
Module: inv_round

Interface
REQ-001 SHALL have parameter DATA_W, default 128, the AES state width in bits; only 128 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_valid_in  input  1  data_in is a valid state this cycle.
REQ-005 SHALL have port key_valid_in  input  1  round_key is valid this cycle.
REQ-006 SHALL have port data_in  input  DATA_W  cipher state; byte data_in[127:120] = s(0,0), then column-major per FIPS-197.
REQ-007 SHALL have port round_key  input  DATA_W  inverse-round key, same byte order as data_in.
REQ-008 SHALL have port last_round  input  1  1 = skip InvMixColumns (present only under INV_ROUND_LAST_EN).
REQ-009 SHALL have port valid_out  output  1  data_out holds a completed inverse round.
REQ-010 SHALL have port data_out  output  DATA_W  inverse-round result.
REQ-011 SHALL have port key_err  output  1  one-cycle pulse: data_valid_in was high while key_valid_in was low.

Function
REQ-012 SHALL compute, in order: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (the mirror of the encrypt round).
REQ-013 SHALL be a 4-stage pipeline, one register stage per operation, each stage with its own valid bit.
REQ-014 SHALL have a latency of exactly 4 cycles, from the accepting edge to valid_out high.
REQ-015 SHALL accept one state per cycle, with no bubbles required between back-to-back inputs.
REQ-016 SHALL accept an input only when data_valid_in=1 and key_valid_in=1 on the same edge.
REQ-017 SHALL carry round_key (and last_round) through the pipeline alongside its data, so key changes never affect in-flight states.
REQ-018 SHALL, when data_valid_in=1 and key_valid_in=0: discard the input and assert key_err on the next cycle for one cycle.
REQ-019 SHALL ignore key_valid_in when data_valid_in=0, and SHALL NOT assert key_err in that case.
REQ-020 SHALL load a stage's data register only when that stage's incoming valid is 1; otherwise the register holds its value.
REQ-021 SHALL assert valid_out for exactly one cycle per accepted input.
REQ-022 SHALL hold data_out at its last value while valid_out=0.
REQ-023 SHALL use GF(2^8) arithmetic with polynomial 0x11B, with InvMixColumns coefficients {0e,0b,0d,09}.

Reset
REQ-024 SHALL, while reset=1, asynchronously clear all stage valids and key_err, and set valid_out=0 and data_out=0.
REQ-025 SHALL discard all in-flight states on reset mid-operation; no valid_out appears for them after reset releases.
REQ-026 SHALL accept a new input on the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL, with INV_ROUND_LAST_EN defined, provide the last_round port; when last_round=1 the stage-4 register loads the AddRoundKey result unmodified, still with 4-cycle latency.
REQ-028 SHALL, with INV_ROUND_LAST_EN undefined, omit the last_round port and always apply InvMixColumns.

Structure
REQ-029 SHALL place the following in shared package aes_pkg: the DATA_W default, the inverse S-box constant table, GF helpers (xtime, mul by 09/0b/0d/0e), and the InvShiftRows byte-index map.
REQ-030 SHALL use one sub-module, inv_sbox (8-bit in, 8-bit out, combinational), instantiated 16 times in stage 2.

Verification
REQ-031 SHALL verify: data_in=0, round_key=0, both valids=1 -> after 4 cycles valid_out=1 and data_out=0x52 repeated 16 times.
REQ-032 SHALL verify: data_in=0, round_key=0xFF repeated 16 times -> data_out=0xAD repeated 16 times.
REQ-033 SHALL verify: data_in=0, round_key=0x01 followed by 30 hex zeros, last_round=0 -> data_out=0x5C5B5F59 followed by 0x52 repeated 12 times; with last_round=1 -> 0x53525252 followed by 0x52 repeated 12 times.
REQ-034 SHALL verify: 8 back-to-back inputs with distinct keys, changing keys every cycle -> 8 consecutive valid_out cycles, in order, each output matching the FIPS-197 Appendix C.1 inverse-round reference model.
REQ-035 SHALL verify: data_valid_in=1 with key_valid_in=0 -> key_err pulses 1 cycle and no valid_out follows 4 cycles later.
REQ-036 SHALL verify: reset asserted 2 cycles after 3 accepted inputs -> valid_out stays 0 and data_out=0 until new inputs are accepted.
